// File: rtl/ps_defs.sv
// Shared symbol definitions for the paralelo_serial / serial_paralelo link pair.
package ps_defs;

    localparam int unsigned SYM_W = 8;
    localparam logic [SYM_W-1:0] COM_SYM = 8'hBC;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } ps_state_e;

endpackage

// File: rtl/paralelo_serial_hold_reg.sv
// One-entry holding buffer between the valid/ready producer and the serializer.
module ps_hold_reg
    import ps_defs::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [SYM_W-1:0] i_data,
    input  logic             i_pop,
    output logic [SYM_W-1:0] o_data,
    output logic             o_full,
    output logic             o_ready
);

    logic             r_full;
    logic [SYM_W-1:0] r_data;
    logic             w_accept;

    assign o_ready  = i_en && !r_full;
    assign w_accept = i_valid && o_ready;
    assign o_data   = r_data;
    assign o_full   = r_full;

    // Accept only happens while empty, so it never races a pop of real data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter: COM preamble after reset, COM idle fill, MSB first.
module paralelo_serial
    import ps_defs::*;
#(
    parameter int unsigned      SYNC_COUNT = 4,
    parameter logic [SYM_W-1:0] COM        = COM_SYM
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic [SYM_W-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out
);

    ps_state_e        r_state;
    ps_state_e        w_state_nxt;
    logic [SYM_W-1:0] r_sym;
    logic [2:0]       r_bit_cnt;
    logic [3:0]       r_sync_cnt;
    logic [2:0]       w_bit_idx;
    logic             w_boundary;
    logic             w_run;
    logic             w_hold_full;
    logic [SYM_W-1:0] w_hold;

    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_run      = (r_state == ST_RUN);
    assign w_bit_idx  = 3'd7 - r_bit_cnt;

    ps_hold_reg u_hold (
        .clk     (clk_32f),
        .rst_n   (reset_L),
        .i_en    (w_run),
        .i_valid (valid_in),
        .i_data  (data_in),
        .i_pop   (w_boundary),
        .o_data  (w_hold),
        .o_full  (w_hold_full),
        .o_ready (ready_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_SYNC && w_boundary && r_sync_cnt == 4'(SYNC_COUNT - 1))
            w_state_nxt = ST_RUN;
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) r_state <= ST_SYNC;
        else          r_state <= w_state_nxt;
    end

    // Hold is sampled before any same-edge accept, so a colliding byte waits a symbol.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            data_out   <= 1'b0;
            r_sym      <= COM;
            r_bit_cnt  <= '0;
            r_sync_cnt <= '0;
        end else begin
            data_out  <= r_sym[w_bit_idx];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_boundary) begin
                r_sym <= w_hold_full ? w_hold : COM;
                if (r_state == ST_SYNC)
                    r_sync_cnt <= r_sync_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial with hand-computed bit streams.
module tb_paralelo_serial;

    logic        clk_32f = 1'b0;
    logic        reset_L;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_out;
    logic        data_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned edge_n   = 0;
    logic [63:0] shreg;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial #(.SYNC_COUNT(4), .COM(8'hBC)) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge; outputs sampled on the following falling edge.
    task automatic tick();
        @(posedge clk_32f);
        @(negedge clk_32f);
        shreg = {shreg[62:0], data_out};
        edge_n++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_preamble(input string pfx);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i < 32) check({pfx, "_ready_low"}, ready_out, 1'b0);
        end
        check({pfx, "_ready_rise"}, ready_out, 1'b1);
        check({pfx, "_com_x4"}, shreg[31:0], 32'hBCBC_BCBC);
        ticks(8);
        check({pfx, "_idle_com"}, shreg[7:0], 8'hBC);
    endtask

    initial begin
        logic [7:0]  vec [4];
        int unsigned idx;
        int unsigned rises;
        logic        prev_ready;
        logic        acc;

        vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03; vec[3] = 8'h04;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        shreg    = '0;

        @(negedge clk_32f);
        @(negedge clk_32f);
        check("reset_data_out", data_out, 1'b0);
        check("reset_ready", ready_out, 1'b0);

        // Preamble: edges 1..32 COM, idle COM on 33..40.
        reset_L = 1'b1;
        check_preamble("pre");

        // Single byte accepted on edge 41 (bit_cnt 0): COM 41-48, A5 49-56, COM 57-64.
        valid_in = 1'b1;
        data_in  = 8'hA5;
        tick();
        valid_in = 1'b0;
        check("sb_ready_drop", ready_out, 1'b0);
        ticks(6);
        check("sb_ready_held", ready_out, 1'b0);
        tick();
        check("sb_ready_rise", ready_out, 1'b1);
        ticks(16);
        check("sb_stream", shreg[23:0], 24'hBC_A5_BC);

        // Back-to-back: accepts on 65,73,81,89; COM 65-72, 01..04 on 73-104, COM 105-112.
        idx = 0;
        rises = 0;
        prev_ready = ready_out;
        for (int i = 0; i < 48; i++) begin
            valid_in = (idx < 4);
            data_in  = (idx < 4) ? vec[idx] : 8'h00;
            acc = valid_in && ready_out;
            tick();
            if (acc) idx++;
            if (ready_out && !prev_ready) rises++;
            prev_ready = ready_out;
        end
        valid_in = 1'b0;
        check("b2b_accepted", idx, 4);
        check("b2b_ready_rises", rises, 4);
        check("b2b_stream", shreg[47:0], 48'hBC_01_02_03_04_BC);

        // Collision: accept on boundary edge 120; COM 113-120, COM 121-128, 3C 129-136.
        ticks(7);
        check("col_ready_pre", ready_out, 1'b1);
        valid_in = 1'b1;
        data_in  = 8'h3C;
        tick();
        valid_in = 1'b0;
        check("col_ready_drop", ready_out, 1'b0);
        ticks(8);
        check("col_ready_rise", ready_out, 1'b1);
        ticks(8);
        check("col_stream", shreg[23:0], 24'hBC_BC_3C);

        // Reset mid-symbol: F0 on air (edges 145-152) with 0F held, cut at edge 148.
        valid_in = 1'b1;
        data_in  = 8'hF0;
        tick();
        valid_in = 1'b0;
        ticks(7);
        valid_in = 1'b1;
        data_in  = 8'h0F;
        tick();
        valid_in = 1'b0;
        ticks(3);
        check("rst_pre_bit", data_out, 1'b1);
        check("rst_pre_ready", ready_out, 1'b0);
        check("rst_pre_bits", shreg[3:0], 4'hF);
        #2;
        reset_L = 1'b0;
        #1;
        check("rst_async_data", data_out, 1'b0);
        check("rst_async_ready", ready_out, 1'b0);
        @(negedge clk_32f);
        @(negedge clk_32f);
        check("rst_hold_data", data_out, 1'b0);
        reset_L = 1'b1;
        shreg = '0;
        check_preamble("rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
